cs_trgt_chan_mgr: RTL and testbench

Parametrised target-side co-simulation channel manager. Sits between the design-under-test partition and the fringe transport adapter. On every rising edge of the mission clock it uploads the DUT output vector, then downloads one payload per input channel, freezing each channel's mission clock until its payload arrives. Channel count, width, watchdog limit and get/put mode are generalised; watchdog expiry raises a sticky error flag instead of ending simulation.

---
 rtl/cs_trgt_pkg.sv | 20 ++
 rtl/cs_trgt_wdog.sv | 27 ++
 rtl/cs_trgt_chan_mgr.sv | 158 +++++++++++++++
 tb/tb_cs_trgt_chan_mgr.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cs_trgt_pkg.sv
// Shared types and defaults for the target-side co-simulation channel manager.
package cs_trgt_pkg;

  localparam int unsigned TRGT_DW       = 8;
  localparam int unsigned TRGT_WDOG_MAX = 10000;

  typedef enum logic [1:0] {
    TRGT_IDLE,
    TRGT_SEND,
    TRGT_WAIT_RX,
    TRGT_ERR
  } trgt_state_e;

  // One transported vector: write enable above the data word.
  typedef struct packed {
    logic               wen;
    logic [TRGT_DW-1:0] data;
  } trgt_vec_t;

endpackage

// File: rtl/cs_trgt_wdog.sv
// Watchdog counter: counts enabled cycles since the last clear and flags the LIMIT-th one.
module cs_trgt_wdog #(
  parameter int unsigned WDW   = 16,
  parameter int unsigned LIMIT = 10000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c_o
);

  logic [WDW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + WDW'(1);
    end
  end

  assign expire_c_o = en_i && (cnt_q == WDW'(LIMIT - 1));

endmodule

// File: rtl/cs_trgt_chan_mgr.sv
// Target-side channel manager: uploads the DUT output on each mission-clock edge,
// then collects one download beat per channel while freezing the waiting channels.
module cs_trgt_chan_mgr
  import cs_trgt_pkg::*;
#(
  parameter int unsigned NCH      = 3,
  parameter int unsigned DW       = 8,
  parameter int unsigned WDOG_MAX = TRGT_WDOG_MAX,
  parameter int unsigned WDW      = 16,
  parameter int unsigned CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mclk_i,
  input  logic              get_en_i,
  input  logic              put_en_i,
  input  logic              up_valid_i,
  input  logic [DW-1:0]     up_data_i,
  output logic [NCH-1:0]    dn_wen_o,
  output logic [NCH*DW-1:0] dn_data_o,
  output logic [NCH-1:0]    freeze_clk_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [DW:0]       tx_data_o,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  input  logic [CW-1:0]     rx_chan_i,
  input  logic [DW:0]       rx_data_i,
  output logic              busy_o,
  output logic              wdog_err_o,
  output logic              ovr_err_o
);

  trgt_state_e       state_q, state_d;
  logic              m_q, m_d;
  logic              trig;
  logic [NCH-1:0]    pending_q, pending_d;
  logic [DW:0]       tx_data_q, tx_data_d;
  logic [NCH-1:0]    dn_wen_q, dn_wen_d;
  logic [NCH*DW-1:0] dn_data_q, dn_data_d;
  logic              tx_valid_q, rx_ready_q, busy_q;
  logic [NCH-1:0]    freeze_q;
  logic              wdog_err_q, ovr_err_q;
  logic              wdog_clr, wdog_exp;
  logic              chan_ok;

  assign trig    = m_q & ~m_d;
  assign chan_ok = ({1'b0, rx_chan_i} < (CW+1)'(NCH));

  cs_trgt_wdog #(
    .WDW   (WDW),
    .LIMIT (WDOG_MAX)
  ) u_wdog (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (wdog_clr),
    .en_i       (state_q == TRGT_WAIT_RX),
    .expire_c_o (wdog_exp)
  );

  // Next-state and datapath next values
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    tx_data_d = tx_data_q;
    dn_wen_d  = dn_wen_q;
    dn_data_d = dn_data_q;
    wdog_clr  = 1'b0;
    case (state_q)
      TRGT_IDLE: begin
        if (trig) begin
          if (put_en_i) begin
            state_d   = TRGT_SEND;
            tx_data_d = {up_valid_i, up_data_i};
          end else if (get_en_i) begin
            state_d   = TRGT_WAIT_RX;
            pending_d = '1;
            wdog_clr  = 1'b1;
          end
        end
      end
      TRGT_SEND: begin
        if (tx_ready_i) begin
          if (get_en_i) begin
            state_d   = TRGT_WAIT_RX;
            pending_d = '1;
            wdog_clr  = 1'b1;
          end else begin
            state_d = TRGT_IDLE;
          end
        end
      end
      TRGT_WAIT_RX: begin
        // Out-of-range channels are accepted but leave all state untouched.
        if (rx_valid_i && chan_ok) begin
          dn_wen_d[rx_chan_i]                        = rx_data_i[DW];
          dn_data_d[int'(rx_chan_i) * int'(DW) +: DW] = rx_data_i[DW-1:0];
          pending_d[rx_chan_i]                       = 1'b0;
        end
        if (pending_d == '0) begin
          state_d = TRGT_IDLE;
        end else if (wdog_exp) begin
          state_d = TRGT_ERR;
        end
      end
      TRGT_ERR: begin
        state_d = TRGT_ERR;
      end
      default: begin
        state_d = TRGT_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= TRGT_IDLE;
      m_q        <= 1'b0;
      m_d        <= 1'b0;
      pending_q  <= '0;
      tx_data_q  <= '0;
      dn_wen_q   <= '0;
      dn_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      freeze_q   <= '0;
      wdog_err_q <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= mclk_i;
      m_d        <= m_q;
      pending_q  <= pending_d;
      tx_data_q  <= tx_data_d;
      dn_wen_q   <= dn_wen_d;
      dn_data_q  <= dn_data_d;
      tx_valid_q <= (state_d == TRGT_SEND);
      rx_ready_q <= (state_d == TRGT_WAIT_RX);
      busy_q     <= (state_d != TRGT_IDLE);
      freeze_q   <= ((state_d == TRGT_WAIT_RX) || (state_d == TRGT_ERR)) ? pending_d : '0;
      wdog_err_q <= wdog_err_q | (state_d == TRGT_ERR);
      ovr_err_q  <= ovr_err_q | (trig && (state_q != TRGT_IDLE));
    end
  end

  assign dn_wen_o     = dn_wen_q;
  assign dn_data_o    = dn_data_q;
  assign freeze_clk_o = freeze_q;
  assign tx_valid_o   = tx_valid_q;
  assign tx_data_o    = tx_data_q;
  assign rx_ready_o   = rx_ready_q;
  assign busy_o       = busy_q;
  assign wdog_err_o   = wdog_err_q;
  assign ovr_err_o    = ovr_err_q;

endmodule

// File: tb/tb_cs_trgt_chan_mgr.sv
// Scoreboard bench for cs_trgt_chan_mgr: directed mission-clock transactions,
// upload and download handshakes checked by independent monitors.
module tb_cs_trgt_chan_mgr;
  import cs_trgt_pkg::*;

  localparam int unsigned NCH = 3;
  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              mclk_i, get_en_i, put_en_i, up_valid_i;
  logic [DW-1:0]     up_data_i;
  logic [NCH-1:0]    dn_wen_o;
  logic [NCH*DW-1:0] dn_data_o;
  logic [NCH-1:0]    freeze_clk_o;
  logic              tx_valid_o, tx_ready_i;
  logic [DW:0]       tx_data_o;
  logic              rx_valid_i, rx_ready_o;
  logic [CW-1:0]     rx_chan_i;
  logic [DW:0]       rx_data_i;
  logic              busy_o, wdog_err_o, ovr_err_o;

  cs_trgt_chan_mgr #(
    .NCH      (NCH),
    .DW       (DW),
    .WDOG_MAX (16),
    .WDW      (16),
    .CW       (CW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .mclk_i       (mclk_i),
    .get_en_i     (get_en_i),
    .put_en_i     (put_en_i),
    .up_valid_i   (up_valid_i),
    .up_data_i    (up_data_i),
    .dn_wen_o     (dn_wen_o),
    .dn_data_o    (dn_data_o),
    .freeze_clk_o (freeze_clk_o),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready_i),
    .tx_data_o    (tx_data_o),
    .rx_valid_i   (rx_valid_i),
    .rx_ready_o   (rx_ready_o),
    .rx_chan_i    (rx_chan_i),
    .rx_data_i    (rx_data_i),
    .busy_o       (busy_o),
    .wdog_err_o   (wdog_err_o),
    .ovr_err_o    (ovr_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  wen;
    logic [23:0] data;
    logic [2:0]  frz;
    logic        busy;
  } rx_exp_t;

  rx_exp_t     exp_rx[$];
  logic [8:0]  exp_tx[$];
  logic [2:0]  m_wen, m_pend;
  logic [23:0] m_data;
  int          errors = 0;
  int          checks = 0;
  rx_exp_t     mon_e;
  logic [8:0]  mon_tx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_zero(input string tag);
    chk({tag, "_txv"},  32'(tx_valid_o),   32'd0);
    chk({tag, "_rxr"},  32'(rx_ready_o),   32'd0);
    chk({tag, "_busy"}, 32'(busy_o),       32'd0);
    chk({tag, "_frz"},  32'(freeze_clk_o), 32'd0);
    chk({tag, "_wdog"}, 32'(wdog_err_o),   32'd0);
    chk({tag, "_ovr"},  32'(ovr_err_o),    32'd0);
    chk({tag, "_wen"},  32'(dn_wen_o),     32'd0);
    chk({tag, "_dn"},   32'(dn_data_o),    32'd0);
    chk({tag, "_txd"},  32'(tx_data_o),    32'd0);
  endtask

  task automatic model_reset();
    m_wen  = '0;
    m_data = '0;
    m_pend = '0;
  endtask

  // Drive one download beat expected to be accepted; push the resulting state.
  task automatic beat(input logic [1:0] ch, input trgt_vec_t v);
    rx_exp_t e;
    if (ch < 2'd3) begin
      m_wen[ch]          = v.wen;
      m_data[ch*8 +: 8]  = v.data;
      m_pend[ch]         = 1'b0;
    end
    e.wen  = m_wen;
    e.data = m_data;
    e.frz  = m_pend;
    e.busy = (m_pend != 3'b000);
    exp_rx.push_back(e);
    rx_valid_i = 1'b1;
    rx_chan_i  = ch;
    rx_data_i  = v;
    tick();
    rx_valid_i = 1'b0;
  endtask

  // Upload monitor
  always @(posedge clk_i) begin
    if (rst_ni && tx_valid_o && tx_ready_i) begin
      if (exp_tx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got %0h expected none", tx_data_o);
      end else begin
        mon_tx = exp_tx.pop_front();
        chk("tx_data", 32'(tx_data_o), 32'(mon_tx));
      end
    end
  end

  // Download monitor: checks outputs one step after each accepted beat
  always @(posedge clk_i) begin
    if (rst_ni && rx_valid_i && rx_ready_o) begin
      #1;
      if (exp_rx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got accept expected none");
      end else begin
        mon_e = exp_rx.pop_front();
        chk("rx_wen",  32'(dn_wen_o),     32'(mon_e.wen));
        chk("rx_data", 32'(dn_data_o),    32'(mon_e.data));
        chk("rx_frz",  32'(freeze_clk_o), 32'(mon_e.frz));
        chk("rx_busy", 32'(busy_o),       32'(mon_e.busy));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0; mclk_i = 1'b0; get_en_i = 1'b0; put_en_i = 1'b0;
    up_valid_i = 1'b0; up_data_i = '0; tx_ready_i = 1'b0;
    rx_valid_i = 1'b0; rx_chan_i = '0; rx_data_i = '0;
    model_reset();
    #12;
    reset_zero("rst");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    tick(); tick();

    // Put + get
    get_en_i = 1'b1; put_en_i = 1'b1; up_valid_i = 1'b1; up_data_i = 8'hA5; tx_ready_i = 1'b1;
    exp_tx.push_back(9'h1A5);
    mclk_i = 1'b1;
    tick();
    chk("t1_txv_early", 32'(tx_valid_o), 32'd0);
    tick();
    chk("t1_txv",  32'(tx_valid_o), 32'd1);
    chk("t1_txd",  32'(tx_data_o),  32'h1A5);
    chk("t1_busy", 32'(busy_o),     32'd1);
    mclk_i = 1'b0; up_valid_i = 1'b0; up_data_i = 8'h00;
    tick();
    chk("t1_rxr",   32'(rx_ready_o),   32'd1);
    chk("t1_frz",   32'(freeze_clk_o), 32'b111);
    chk("t1_txoff", 32'(tx_valid_o),   32'd0);
    m_pend = 3'b111;
    beat(2'd2, 9'h111);
    beat(2'd0, 9'h1FF);
    beat(2'd1, 9'h022);
    chk("t1_done_busy", 32'(busy_o),     32'd0);
    chk("t1_done_rxr",  32'(rx_ready_o), 32'd0);
    chk("t1_dn",        32'(dn_data_o),  32'h1122FF);
    tick(); tick();

    // Get only, with an out-of-range beat
    put_en_i = 1'b0;
    mclk_i = 1'b1;
    tick();
    chk("t2_rxr_early", 32'(rx_ready_o), 32'd0);
    tick();
    chk("t2_rxr", 32'(rx_ready_o), 32'd1);
    chk("t2_txv", 32'(tx_valid_o), 32'd0);
    mclk_i = 1'b0;
    m_pend = 3'b111;
    beat(2'd3, 9'h1AB);
    chk("t2_frz_drop", 32'(freeze_clk_o), 32'b111);
    beat(2'd0, 9'h033);
    beat(2'd1, 9'h144);
    beat(2'd2, 9'h055);
    chk("t2_busy", 32'(busy_o), 32'd0);
    tick(); tick();

    // Watchdog expiry with only channel 0 delivered
    mclk_i = 1'b1;
    tick(); tick();
    chk("t3_rxr", 32'(rx_ready_o), 32'd1);
    mclk_i = 1'b0;
    m_pend = 3'b111;
    beat(2'd0, 9'h0EE);
    repeat (14) tick();
    chk("t3_wdog_pre", 32'(wdog_err_o), 32'd0);
    chk("t3_rxr_pre",  32'(rx_ready_o), 32'd1);
    tick();
    chk("t3_wdog", 32'(wdog_err_o),   32'd1);
    chk("t3_frz",  32'(freeze_clk_o), 32'b110);
    chk("t3_rxr",  32'(rx_ready_o),   32'd0);
    chk("t3_busy", 32'(busy_o),       32'd1);
    rx_valid_i = 1'b1; rx_chan_i = 2'd1; rx_data_i = 9'h1DD;
    repeat (3) tick();
    rx_valid_i = 1'b0;
    chk("t3_frz_hold",  32'(freeze_clk_o), 32'b110);
    chk("t3_dn_hold",   32'(dn_data_o),    32'h5544EE);
    chk("t3_wdog_hold", 32'(wdog_err_o),   32'd1);

    #3 rst_ni = 1'b0;
    #1 reset_zero("rst_err");
    model_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    tick();

    // Upload backpressure with an overrunning trigger
    put_en_i = 1'b1; get_en_i = 1'b1; tx_ready_i = 1'b0;
    up_valid_i = 1'b1; up_data_i = 8'h3C;
    exp_tx.push_back(9'h13C);
    mclk_i = 1'b1;
    tick(); tick();
    chk("t4_txv", 32'(tx_valid_o), 32'd1);
    chk("t4_txd", 32'(tx_data_o),  32'h13C);
    chk("t4_ovr_pre", 32'(ovr_err_o), 32'd0);
    mclk_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up_data_i  = 8'h40 + 8'(i);
      up_valid_i = (i % 2) == 1;
      if (i == 1) mclk_i = 1'b1;
      if (i == 3) mclk_i = 1'b0;
      tick();
      chk("t4_txd_hold", 32'(tx_data_o),  32'h13C);
      chk("t4_txv_hold", 32'(tx_valid_o), 32'd1);
    end
    chk("t4_ovr", 32'(ovr_err_o), 32'd1);
    tx_ready_i = 1'b1;
    tick();
    chk("t4_rxr", 32'(rx_ready_o),   32'd1);
    chk("t4_frz", 32'(freeze_clk_o), 32'b111);
    m_pend = 3'b111;
    beat(2'd0, 9'h1C1);
    beat(2'd2, 9'h0C2);
    chk("t4_frz_mid", 32'(freeze_clk_o), 32'b010);

    // Asynchronous reset while one channel is still pending
    #3 rst_ni = 1'b0;
    #1 reset_zero("rst_wait");
    model_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    tick(); tick();

    // Normal transaction after reset
    up_valid_i = 1'b0; up_data_i = 8'h77;
    exp_tx.push_back(9'h077);
    mclk_i = 1'b1;
    tick();
    chk("t5_txv_early", 32'(tx_valid_o), 32'd0);
    tick();
    chk("t5_txv", 32'(tx_valid_o), 32'd1);
    chk("t5_txd", 32'(tx_data_o),  32'h077);
    mclk_i = 1'b0;
    tick();
    chk("t5_rxr", 32'(rx_ready_o), 32'd1);
    m_pend = 3'b111;
    beat(2'd1, 9'h1AA);
    beat(2'd0, 9'h0BB);
    beat(2'd2, 9'h1CC);
    chk("t5_busy", 32'(busy_o),     32'd0);
    chk("t5_wdog", 32'(wdog_err_o), 32'd0);
    chk("t5_ovr",  32'(ovr_err_o),  32'd0);
    chk("t5_wen",  32'(dn_wen_o),   32'b110);
    tick(); tick();

    chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    chk("rx_queue_empty", 32'(exp_rx.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
